// File: rtl/quire_window_arbiter.sv
// Window-granular round-robin arbiter that shares one quire among NB_REQ product streams
// and tags each returned quire result with the id of the requester that owned the window.
module quire_window_arbiter #(
  parameter  int NB_REQ        = 4,
  parameter  int DATA_WIDTH    = 18,
  parameter  int QUIRE_WIDTH   = 64,
  parameter  int ID_FIFO_DEPTH = 4,
  localparam int ID_W          = $clog2(NB_REQ)
) (
  input  logic                         tb_clk,
  input  logic                         tb_reset_n,
  input  logic [NB_REQ-1:0]            req_rts_i,
  input  logic [NB_REQ-1:0]            req_sow_i,
  input  logic [NB_REQ-1:0]            req_eow_i,
  input  logic [NB_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NB_REQ-1:0]            req_rtr_o,
  output logic                         q_rts_o,
  output logic                         q_sow_o,
  output logic                         q_eow_o,
  output logic [DATA_WIDTH-1:0]        q_data_o,
  input  logic                         q_rtr_i,
  input  logic                         qr_rts_i,
  input  logic                         qr_eow_i,
  input  logic [QUIRE_WIDTH-1:0]       qr_data_i,
  output logic                         qr_rtr_o,
  output logic                         res_rts_o,
  output logic                         res_eow_o,
  output logic [QUIRE_WIDTH-1:0]       res_data_o,
  output logic [ID_W-1:0]              res_id_o,
  input  logic                         res_rtr_i,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int PTR_W = $clog2(ID_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_grant;
  logic [ID_W-1:0]     r_rr_ptr;
  logic                r_first;
  logic                r_err;
  logic [ID_W-1:0]     r_fifo [ID_FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic [NB_REQ-1:0]   w_cand;
  logic [NB_REQ-1:0]   w_rot;
  logic [ID_W-1:0]     w_idx [NB_REQ];
  logic                w_pick_valid;
  logic [ID_W-1:0]     w_pick;
  logic [ID_W:0]       w_ginc_sum;
  logic [ID_W-1:0]     w_grant_inc;
  logic                w_busy;
  logic                w_q_hs;
  logic                w_push;
  logic                w_pop;
  logic                w_fifo_empty;
  logic                w_fifo_full;
  logic [NB_REQ-1:0]   w_rtr;

  assign w_cand = req_rts_i & req_sow_i;

  // w_rot[i] is the candidate i positions after rr_ptr, so the lowest set bit wins
  for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_rot
    logic [ID_W:0] w_sum;
    assign w_sum      = {1'b0, r_rr_ptr} + (ID_W+1)'(gi);
    assign w_idx[gi]  = (w_sum >= (ID_W+1)'(NB_REQ)) ? ID_W'(w_sum - (ID_W+1)'(NB_REQ))
                                                     : ID_W'(w_sum);
    assign w_rot[gi]  = w_cand[w_idx[gi]];
  end

  always_comb begin
    w_pick_valid = 1'b0;
    w_pick       = '0;
    for (int i = NB_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_pick_valid = 1'b1;
        w_pick       = w_idx[i];
      end
    end
  end

  assign w_ginc_sum  = {1'b0, r_grant} + 1'b1;
  assign w_grant_inc = (w_ginc_sum == (ID_W+1)'(NB_REQ)) ? '0 : w_ginc_sum[ID_W-1:0];

  assign w_busy   = (r_state == S_BUSY);
  assign q_rts_o  = w_busy & req_rts_i[r_grant];
  assign q_sow_o  = w_busy & req_sow_i[r_grant];
  assign q_eow_o  = w_busy & req_eow_i[r_grant];
  assign q_data_o = w_busy ? req_data_i[r_grant*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_comb begin
    w_rtr = '0;
    if (w_busy) w_rtr[r_grant] = q_rtr_i;
  end
  assign req_rtr_o = w_rtr;

  assign w_q_hs       = q_rts_o & q_rtr_i;
  assign w_push       = w_q_hs & q_eow_o;
  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == CNT_W'(ID_FIFO_DEPTH));

  assign res_rts_o  = qr_rts_i & ~w_fifo_empty;
  assign qr_rtr_o   = res_rtr_i & ~w_fifo_empty;
  assign res_eow_o  = qr_eow_i;
  assign res_data_o = qr_data_i;
  assign res_id_o   = r_fifo[r_rd_ptr];
  assign w_pop      = qr_rts_i & qr_rtr_o & qr_eow_i;

  assign busy_o = w_busy;
  assign err_o  = r_err;

  always_ff @(posedge tb_clk or negedge tb_reset_n) begin
    if (!tb_reset_n) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_first  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      // A result with no owning window is held off and flagged
      if (qr_rts_i & w_fifo_empty) r_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_pick_valid & ~w_fifo_full) begin
            r_grant <= w_pick;
            r_first <= 1'b1;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_q_hs) begin
            r_first <= 1'b0;
            if (q_sow_o & ~r_first) r_err <= 1'b1;
            if (q_eow_o) begin
              r_rr_ptr <= w_grant_inc;
              r_state  <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge tb_clk or negedge tb_reset_n) begin
    if (!tb_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Id storage needs no reset: the pointers and count define what is valid
  always_ff @(posedge tb_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= r_grant;
  end

endmodule

// File: tb/tb_quire_window_arbiter.sv
// Bench for quire_window_arbiter: window-level requester agents and a queue-based
// reference model of grants, round-robin order and result id tagging.
module tb_quire_window_arbiter;

  logic        tb_clk = 1'b0;
  logic        tb_reset_n;
  logic [3:0]  req_rts_i, req_sow_i, req_eow_i;
  logic [71:0] req_data_i;
  logic [3:0]  req_rtr_o;
  logic        q_rts_o, q_sow_o, q_eow_o;
  logic [17:0] q_data_o;
  logic        q_rtr_i;
  logic        qr_rts_i, qr_eow_i;
  logic [63:0] qr_data_i;
  logic        qr_rtr_o, res_rts_o, res_eow_o;
  logic [63:0] res_data_o;
  logic [1:0]  res_id_o;
  logic        res_rtr_i;
  logic        busy_o, err_o;

  quire_window_arbiter dut (
    .tb_clk(tb_clk), .tb_reset_n(tb_reset_n),
    .req_rts_i(req_rts_i), .req_sow_i(req_sow_i), .req_eow_i(req_eow_i),
    .req_data_i(req_data_i), .req_rtr_o(req_rtr_o),
    .q_rts_o(q_rts_o), .q_sow_o(q_sow_o), .q_eow_o(q_eow_o), .q_data_o(q_data_o),
    .q_rtr_i(q_rtr_i),
    .qr_rts_i(qr_rts_i), .qr_eow_i(qr_eow_i), .qr_data_i(qr_data_i), .qr_rtr_o(qr_rtr_o),
    .res_rts_o(res_rts_o), .res_eow_o(res_eow_o), .res_data_o(res_data_o),
    .res_id_o(res_id_o), .res_rtr_i(res_rtr_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 tb_clk = ~tb_clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference model: window owner, round-robin pointer, queue of ids awaiting results
  bit m_busy, m_first, m_err;
  int m_g, m_rr;
  int m_q[$];

  // Requester agents: each holds at most one window of a_len beats
  bit [3:0] a_act, a_glitch;
  int       a_len[4];
  int       a_beat[4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic start_window(input int k, input int len);
    a_act[k]  = 1'b1;
    a_len[k]  = len;
    a_beat[k] = 0;
  endtask

  task automatic model_reset();
    m_busy = 0; m_first = 0; m_err = 0; m_g = 0; m_rr = 0;
    m_q.delete();
    a_act = '0; a_glitch = '0;
    req_rts_i = '0; req_sow_i = '0; req_eow_i = '0; req_data_i = '0;
  endtask

  task automatic cycle();
    logic [3:0]  exp_rtr;
    logic        exp_qrts, exp_qsow, exp_qeow;
    logic [17:0] exp_qdata;
    int          sz, k;
    bit          pop, push, granted;
    int          push_id;
    for (int j = 0; j < 4; j++) begin
      req_rts_i[j] = a_act[j];
      req_sow_i[j] = a_act[j] && (a_beat[j] == 0 || a_glitch[j]);
      req_eow_i[j] = a_act[j] && (a_beat[j] == a_len[j] - 1);
      req_data_i[j*18 +: 18] = {2'(j), 4'(a_beat[j]), 12'(cyc)};
    end
    #1;
    exp_rtr = '0; exp_qrts = 0; exp_qsow = 0; exp_qeow = 0; exp_qdata = '0;
    if (m_busy) begin
      exp_rtr[m_g] = q_rtr_i;
      exp_qrts     = req_rts_i[m_g];
      exp_qsow     = req_sow_i[m_g];
      exp_qeow     = req_eow_i[m_g];
      exp_qdata    = req_data_i[m_g*18 +: 18];
    end
    sz = m_q.size();
    check("req_rtr", req_rtr_o, exp_rtr);
    check("q_rts", q_rts_o, exp_qrts);
    check("q_sow", q_sow_o, exp_qsow);
    check("q_eow", q_eow_o, exp_qeow);
    check("q_data", q_data_o, exp_qdata);
    check("busy", busy_o, m_busy);
    check("err", err_o, m_err);
    check("res_rts", res_rts_o, qr_rts_i && sz > 0);
    check("qr_rtr", qr_rtr_o, res_rtr_i && sz > 0);
    check("res_eow", res_eow_o, qr_eow_i);
    check("res_data", res_data_o, qr_data_i);
    if (sz > 0) check("res_id", res_id_o, m_q[0]);

    pop  = qr_rts_i && res_rtr_i && sz > 0 && qr_eow_i;
    push = 0; push_id = 0;
    if (qr_rts_i && sz == 0) m_err = 1;
    if (m_busy) begin
      if (req_rts_i[m_g] && q_rtr_i) begin
        if (req_sow_i[m_g] && !m_first) m_err = 1;
        m_first = 0;
        if (req_eow_i[m_g]) begin
          push = 1; push_id = m_g;
          m_rr = (m_g + 1) % 4;
          m_busy = 0;
          a_act[m_g] = 1'b0;
        end else begin
          a_beat[m_g]++;
        end
      end
    end else if (sz < 4) begin
      granted = 0;
      for (int i = 0; i < 4; i++) begin
        k = (m_rr + i) % 4;
        if (!granted && req_rts_i[k] && req_sow_i[k]) begin
          granted = 1; m_busy = 1; m_g = k; m_first = 1;
        end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(push_id);
    @(posedge tb_clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_idle(input string tag);
    for (int i = 0; i < 60 && (a_act != 0 || m_busy); i++) cycle();
    check(tag, {a_act, 3'b0, m_busy}, 8'h0);
  endtask

  task automatic ret_result(input int exp_id, input string tag);
    qr_rts_i  = 1'b1;
    qr_eow_i  = 1'b1;
    res_rtr_i = 1'b1;
    qr_data_i = {$urandom, $urandom};
    #1;
    check(tag, res_id_o, exp_id);
    cycle();
    qr_rts_i = 1'b0;
    qr_eow_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 8 && m_q.size() > 0; i++) ret_result(m_q[0], "drain_id");
    res_rtr_i = 1'b1;
    #1;
    check(tag, qr_rtr_o, 1'b0);
  endtask

  task automatic do_reset();
    qr_rts_i = 1'b0; qr_eow_i = 1'b0;
    tb_reset_n = 1'b0;
    model_reset();
    #2;
    tb_reset_n = 1'b1;
    @(posedge tb_clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tb_reset_n = 1'b0;
    q_rtr_i = 1'b0; qr_rts_i = 1'b0; qr_eow_i = 1'b0; qr_data_i = '0; res_rtr_i = 1'b0;
    model_reset();
    #1;
    check("rst_busy", busy_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_req_rtr", req_rtr_o, 4'b0);
    check("rst_q_rts", q_rts_o, 1'b0);
    check("rst_res_rts", res_rts_o, 1'b0);
    @(posedge tb_clk);
    #1;
    tb_reset_n = 1'b1;

    // Single requester, 3-beat window, one result back with id 0
    q_rtr_i = 1'b1;
    start_window(0, 3);
    cycle();
    check("t1_busy_after_sow", busy_o, 1'b1);
    run_until_idle("t1_window_done");
    res_rtr_i = 1'b1;
    #1;
    check("t1_fifo_one", qr_rtr_o, 1'b1);
    ret_result(0, "t1_res_id0");
    check("t1_fifo_empty", qr_rtr_o, 1'b0);

    // Move rr_ptr to 2, then 1 and 3 contend: 3 first
    start_window(1, 2);
    run_until_idle("t2_pre_done");
    ret_result(1, "t2_pre_id1");
    start_window(1, 2);
    start_window(3, 3);
    cycle();
    check("t2_grant3", req_rtr_o, 4'b1000);
    run_until_idle("t2_windows_done");
    ret_result(3, "t2_res_id3");
    ret_result(1, "t2_res_id1");

    // Four single-beat windows fill the id FIFO; a fifth waits for a pop
    do_reset();
    q_rtr_i = 1'b1; res_rtr_i = 1'b1;
    for (int k = 0; k < 4; k++) start_window(k, 1);
    run(8);
    check("t3_all_granted", a_act, 4'b0);
    start_window(0, 1);
    run(3);
    check("t3_full_no_grant", busy_o, 1'b0);
    ret_result(0, "t3_res_id0");
    check("t3_pop_cycle_idle", busy_o, 1'b0);
    cycle();
    check("t3_fifth_grant", busy_o, 1'b1);
    run_until_idle("t3_fifth_done");
    ret_result(1, "t3_res_id1");
    ret_result(2, "t3_res_id2");
    ret_result(3, "t3_res_id3");
    ret_result(0, "t3_res_id0b");

    // Quire backpressure toggles inside a window while another requester waits
    start_window(2, 3);
    start_window(1, 2);
    q_rtr_i = 1'b1; cycle();
    q_rtr_i = 1'b1; cycle();
    q_rtr_i = 1'b0; cycle();
    q_rtr_i = 1'b1; cycle();
    run_until_idle("t4_windows_done");
    drain("t4_drained");

    // Orphan result: flagged, held, sticky
    qr_rts_i = 1'b1; qr_eow_i = 1'b1; res_rtr_i = 1'b1;
    #1;
    check("t5_orphan_held", qr_rtr_o, 1'b0);
    cycle();
    check("t5_err_set", err_o, 1'b1);
    qr_rts_i = 1'b0; qr_eow_i = 1'b0;
    cycle();
    check("t5_err_sticky", err_o, 1'b1);

    // Reset in the middle of a window
    start_window(1, 4);
    run(3);
    tb_reset_n = 1'b0;
    #1;
    check("t6_rst_busy", busy_o, 1'b0);
    check("t6_rst_req_rtr", req_rtr_o, 4'b0);
    check("t6_rst_q_rts", q_rts_o, 1'b0);
    check("t6_rst_err", err_o, 1'b0);
    do_reset();
    q_rtr_i = 1'b1;
    start_window(3, 2);
    start_window(1, 2);
    cycle();
    check("t6_grant_from_rr0", req_rtr_o, 4'b0010);
    run_until_idle("t6_windows_done");
    ret_result(1, "t6_res_id1");
    ret_result(3, "t6_res_id3");

    // Randomised traffic including backpressure, orphan results and mid-window sow
    do_reset();
    for (int n = 0; n < 400; n++) begin
      q_rtr_i   = ($urandom % 4) != 0;
      res_rtr_i = $urandom % 2;
      qr_rts_i  = ($urandom % 3) == 0;
      qr_eow_i  = $urandom % 2;
      qr_data_i = {$urandom, $urandom};
      for (int k = 0; k < 4; k++) begin
        if (!a_act[k] && ($urandom % 3) == 0) start_window(k, 1 + int'($urandom % 4));
        a_glitch[k] = ($urandom % 16) == 0;
      end
      cycle();
    end
    a_glitch = '0; q_rtr_i = 1'b1; qr_rts_i = 1'b0; qr_eow_i = 1'b0; res_rtr_i = 1'b1;
    for (int n = 0; n < 100 && (a_act != 0 || m_busy || m_q.size() > 0); n++) begin
      if (m_q.size() > 0) ret_result(m_q[0], "rand_res_id");
      else cycle();
    end
    check("rand_settled", {a_act, 3'b0, m_busy}, 8'h0);
    drain("rand_drained");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
